// File: rtl/printing_department_pkg.sv
// Shared types and constants for the printing-department grid path.
// Used by the ASCII loader and the roll-removal engine.
package printing_department_pkg;

  localparam int DEF_WIDTH  = 140;
  localparam int DEF_HEIGHT = 140;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_LENGTH  = 2'd2,
    ERR_TRAILER = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/grid_char_decode.sv
// Classifies one ASCII byte of the puzzle grid stream.
module grid_char_decode
  import printing_department_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_cell,
  output logic       cell_bit,
  output logic       is_lf,
  output logic       is_ignored,
  output logic       is_illegal
);

  always_comb begin
    is_cell    = 1'b0;
    cell_bit   = 1'b0;
    is_lf      = 1'b0;
    is_ignored = 1'b0;
    is_illegal = 1'b0;
    unique case (data)
      CH_ROLL: begin
        is_cell  = 1'b1;
        cell_bit = 1'b1;
      end
      CH_EMPTY: is_cell    = 1'b1;
      CH_LF:    is_lf      = 1'b1;
      CH_CR:    is_ignored = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/grid_ascii_loader.sv
// Packs an ASCII '@'/'.' grid stream into row words and writes
// them one row per cycle into the removal engine's grid bank.
module grid_ascii_loader
  import printing_department_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int AW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             row_we,
  output logic [AW-1:0]    row_addr,
  output logic [WIDTH-1:0] row_data,
  output logic             loaded,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [14:0]      roll_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COL_FULL = CW'(WIDTH);
  localparam logic [AW:0]   ROW_LAST = (AW + 1)'(HEIGHT - 1);
  localparam logic [AW:0]   ROW_END  = (AW + 1)'(HEIGHT);

  ld_state_t        state;
  logic [CW-1:0]    col;
  logic [AW:0]      row_cnt;
  logic [WIDTH-1:0] shreg;

  logic is_cell, cell_bit, is_lf, is_ignored, is_illegal;
  logic accept, bad, row_done;
  err_t bad_code;

  grid_char_decode u_dec (
    .data       (in_data),
    .is_cell    (is_cell),
    .cell_bit   (cell_bit),
    .is_lf      (is_lf),
    .is_ignored (is_ignored),
    .is_illegal (is_illegal)
  );

  assign accept   = in_valid && in_ready;
  assign row_done = is_lf && (col == COL_FULL);

  // Trailer check first: it outranks the per-character classification.
  always_comb begin
    bad      = 1'b0;
    bad_code = ERR_NONE;
    if (row_cnt >= ROW_END && !is_lf && !is_ignored) begin
      bad      = 1'b1;
      bad_code = ERR_TRAILER;
    end else if (is_illegal) begin
      bad      = 1'b1;
      bad_code = ERR_ILLEGAL;
    end else if (is_cell && col == COL_FULL) begin
      bad      = 1'b1;
      bad_code = ERR_LENGTH;
    end else if (is_lf && col != COL_FULL && col != '0) begin
      bad      = 1'b1;
      bad_code = ERR_LENGTH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LD_IDLE;
      col        <= '0;
      row_cnt    <= '0;
      shreg      <= '0;
      in_ready   <= 1'b0;
      row_we     <= 1'b0;
      row_addr   <= '0;
      row_data   <= '0;
      loaded     <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      roll_count <= '0;
    end else begin
      row_we <= 1'b0;
      unique case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state      <= LD_LOAD;
            col        <= '0;
            row_cnt    <= '0;
            shreg      <= '0;
            in_ready   <= 1'b1;
            loaded     <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            roll_count <= '0;
          end
        end
        LD_LOAD: begin
          if (accept) begin
            if (bad) begin
              state    <= LD_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
              err_code <= bad_code;
            end else if (is_cell) begin
              shreg      <= {shreg[WIDTH-2:0], cell_bit};
              col        <= col + 1'b1;
              roll_count <= roll_count + 15'(cell_bit);
            end else if (row_done) begin
              row_data <= shreg;
              row_addr <= row_cnt[AW-1:0];
              row_we   <= 1'b1;
              row_cnt  <= row_cnt + 1'b1;
              col      <= '0;
              if (row_cnt == ROW_LAST) begin
                state    <= LD_DONE;
                in_ready <= 1'b0;
                loaded   <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
